// File: rtl/sw_capture_debounce.sv
// Switch front end for the D flip-flop lab: two-flop synchronisers, per-switch
// debounce, and a one-cycle capture strobe that latches debounced SW0 into LED0.

module sw_capture_debounce_ch #(
  parameter int DEB_CYCLES = 16,
  parameter int DEB_W      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam logic [DEB_W-1:0] C_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] C_ZERO = {DEB_W{1'b0}};
  localparam logic [DEB_W-1:0] C_ONE  = {{(DEB_W-1){1'b0}}, 1'b1};

  logic             s1_r;
  logic             s2_r;
  logic             db_r;
  logic [DEB_W-1:0] c_r;
  logic             db_nxt_s;
  logic [DEB_W-1:0] c_nxt_s;

  // Next-state for the stable level and its run-length counter; only s2 is trusted.
  always_comb begin
    db_nxt_s = db_r;
    c_nxt_s  = c_r;
    if (s2_r == db_r) begin
      c_nxt_s = C_ZERO;
    end else if (c_r < C_LAST) begin
      c_nxt_s = c_r + C_ONE;
    end else begin
      db_nxt_s = s2_r;
      c_nxt_s  = C_ZERO;
    end
  end

  // Synchroniser and debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      db_r <= 1'b0;
      c_r  <= C_ZERO;
    end else begin
      s1_r <= raw;
      s2_r <= s1_r;
      db_r <= db_nxt_s;
      c_r  <= c_nxt_s;
    end
  end

  assign db = db_r;

endmodule

module sw_capture_debounce #(
  parameter int DEB_CYCLES = 16,
  parameter int DEB_W      = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SW0,
  input  logic       SW1,
  output logic       LED0,
  output logic       SW0_DB,
  output logic       SW1_DB,
  output logic       STB,
  output logic [7:0] CNT
);

  logic       sw0_db_s;
  logic       sw1_db_s;
  logic       sw1_db_q_r;
  logic       led0_r;
  logic [7:0] cnt_r;

  sw_capture_debounce_ch #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_ch0 (
    .clk (CLK),
    .rst (RST),
    .raw (SW0),
    .db  (sw0_db_s)
  );

  sw_capture_debounce_ch #(
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) u_ch1 (
    .clk (CLK),
    .rst (RST),
    .raw (SW1),
    .db  (sw1_db_s)
  );

  // Strobe is built purely from registered levels, so it cannot glitch.
  assign STB = sw1_db_s & ~sw1_db_q_r;

  // Edge-detect delay flop plus the capture register and its counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sw1_db_q_r <= 1'b0;
      led0_r     <= 1'b0;
      cnt_r      <= 8'd0;
    end else begin
      sw1_db_q_r <= sw1_db_s;
      if (STB) begin
        led0_r <= sw0_db_s;
        cnt_r  <= cnt_r + 8'd1;
      end else begin
        led0_r <= led0_r;
        cnt_r  <= cnt_r;
      end
    end
  end

  assign LED0   = led0_r;
  assign SW0_DB = sw0_db_s;
  assign SW1_DB = sw1_db_s;
  assign CNT    = cnt_r;

endmodule

// File: tb/tb_sw_capture_debounce.sv
// Self-checking bench for sw_capture_debounce with DEB_CYCLES=4, DEB_W=3.
// Segment vectors from a table, a capture scoreboard, and hand-timed corner cases.

module tb_sw_capture_debounce;

  logic       CLK;
  logic       RST;
  logic       SW0;
  logic       SW1;
  logic       LED0;
  logic       SW0_DB;
  logic       SW1_DB;
  logic       STB;
  logic [7:0] CNT;

  sw_capture_debounce #(
    .DEB_CYCLES (4),
    .DEB_W      (3)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .SW0    (SW0),
    .SW1    (SW1),
    .LED0   (LED0),
    .SW0_DB (SW0_DB),
    .SW1_DB (SW1_DB),
    .STB    (STB),
    .CNT    (CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic       rst;
    logic       sw0;
    logic       sw1;
    int         cyc;
    logic       chk;
    logic       led;
    logic       sw0db;
    logic       sw1db;
    logic [7:0] cnt;
    int         stb;
    logic       cap;
  } vec_t;

  vec_t       tbl[$];
  logic [8:0] capq[$];
  int         n_chk;
  int         n_pass;
  int         stb_seen;
  logic       prev_stb;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // One clock: outputs are sampled on the falling edge; a capture is due the edge after STB.
  task automatic step(input int n);
    logic [8:0] e;
    for (int k = 0; k < n; k++) begin
      @(posedge CLK);
      @(negedge CLK);
      if (prev_stb) begin
        if (capq.size() == 0) begin
          check("unexpected_capture", 8'd1, 8'd0);
        end else begin
          e = capq.pop_front();
          check("cap_led", {7'd0, LED0}, {7'd0, e[8]});
          check("cap_cnt", CNT, e[7:0]);
        end
      end
      prev_stb = (STB === 1'b1);
      if (STB === 1'b1) stb_seen++;
    end
  endtask

  task automatic add(input logic rst, input logic sw0, input logic sw1, input int cyc,
                     input logic chk, input logic led, input logic sw0db, input logic sw1db,
                     input logic [7:0] cnt, input int stb, input logic cap);
    vec_t v;
    v = '{rst, sw0, sw1, cyc, chk, led, sw0db, sw1db, cnt, stb, cap};
    tbl.push_back(v);
  endtask

  task automatic run_vectors(input int first, input int last);
    stb_seen = 0;
    for (int i = first; i <= last; i++) begin
      RST = tbl[i].rst;
      SW0 = tbl[i].sw0;
      SW1 = tbl[i].sw1;
      if (tbl[i].cap) capq.push_back({tbl[i].led, tbl[i].cnt});
      step(tbl[i].cyc);
      if (tbl[i].chk) begin
        check("vec_led0",   {7'd0, LED0},   {7'd0, tbl[i].led});
        check("vec_sw0_db", {7'd0, SW0_DB}, {7'd0, tbl[i].sw0db});
        check("vec_sw1_db", {7'd0, SW1_DB}, {7'd0, tbl[i].sw1db});
        check("vec_cnt",    CNT,            tbl[i].cnt);
        check("vec_stb_count", 8'(stb_seen), 8'(tbl[i].stb));
        stb_seen = 0;
      end
    end
  endtask

  initial begin
    n_chk    = 0;
    n_pass   = 0;
    stb_seen = 0;
    prev_stb = 1'b0;
    RST = 1'b1;
    SW0 = 1'b0;
    SW1 = 1'b0;

    //  rst   sw0   sw1  cyc chk  led  sw0db sw1db cnt  stb cap
    add(1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0);  // 0 reset
    add(1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0); // 1 idle
    add(1'b0, 1'b1, 1'b0, 8, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 0, 1'b0);  // 2 release SW1
    add(1'b0, 1'b1, 1'b1, 3, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 0, 1'b0);  // 3 short pulse
    add(1'b0, 1'b1, 1'b0, 8, 1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 0, 1'b0);  // 4 ignored
    add(1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 0, 1'b1);  // 5 minimal pulse
    add(1'b0, 1'b1, 1'b0, 10, 1'b1, 1'b1, 1'b1, 1'b0, 8'd2, 1, 1'b0); // 6 accepted once
    add(1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2, 0, 1'b0);  // 7 SW0 low
    add(1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0);  // 8 bounce
    add(1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 0, 1'b0);
    add(1'b0, 1'b0, 1'b1, 10, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 1, 1'b1); // 12 settle high
    add(1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3, 0, 1'b0); // 13 fall: no STB
    add(1'b0, 1'b1, 1'b1, 10, 1'b1, 1'b1, 1'b1, 1'b1, 8'd4, 1, 1'b1); // 14 simultaneous
    add(1'b0, 1'b0, 1'b1, 10, 1'b1, 1'b1, 1'b0, 1'b1, 8'd4, 0, 1'b0); // 15 SW0 while held
    add(1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b1, 1'b0, 1'b0, 8'd4, 0, 1'b0); // 16 release

    run_vectors(0, 1);

    // Exact latency of a clean SW1 rise with SW0 already settled high.
    SW0 = 1'b1;
    step(10);
    check("t2_sw0_db", {7'd0, SW0_DB}, 8'd1);
    check("t2_led_pre", {7'd0, LED0}, 8'd0);
    stb_seen = 0;
    SW1 = 1'b1;
    capq.push_back({1'b1, 8'd1});
    step(5);
    check("t2_sw1_db_e5", {7'd0, SW1_DB}, 8'd0);
    check("t2_stb_e5", {7'd0, STB}, 8'd0);
    step(1);
    check("t2_sw1_db_e6", {7'd0, SW1_DB}, 8'd1);
    check("t2_stb_e6", {7'd0, STB}, 8'd1);
    step(1);
    check("t2_stb_e7", {7'd0, STB}, 8'd0);
    check("t2_led_e7", {7'd0, LED0}, 8'd1);
    check("t2_cnt_e7", CNT, 8'd1);
    step(5);
    check("t2_cnt_hold", CNT, 8'd1);
    check("t2_stb_count", 8'(stb_seen), 8'd1);

    run_vectors(2, 16);

    // Counter wrap over 256 presses, SW0 changing together with SW1.
    RST = 1'b1;
    SW0 = 1'b0;
    SW1 = 1'b0;
    step(2);
    check("t6_rst_led", {7'd0, LED0}, 8'd0);
    check("t6_rst_cnt", CNT, 8'd0);
    RST = 1'b0;
    for (int i = 0; i < 256; i++) begin
      SW0 = i[0];
      SW1 = 1'b1;
      capq.push_back({i[0], 8'(i + 1)});
      step(7);
      SW1 = 1'b0;
      step(6);
    end
    check("t6_cnt_wrap", CNT, 8'd0);

    // Reset in the middle of a pending SW1 rise, SW1 held through release.
    SW1 = 1'b1;
    step(3);
    RST = 1'b1;
    step(1);
    check("t6_mid_sw1_db", {7'd0, SW1_DB}, 8'd0);
    check("t6_mid_led", {7'd0, LED0}, 8'd0);
    RST = 1'b0;
    stb_seen = 0;
    capq.push_back({1'b1, 8'd1});
    step(5);
    check("t6_stb_e5", {7'd0, STB}, 8'd0);
    step(1);
    check("t6_stb_e6", {7'd0, STB}, 8'd1);
    step(1);
    check("t6_cnt_e7", CNT, 8'd1);
    check("t6_led_e7", {7'd0, LED0}, 8'd1);
    step(4);
    check("t6_stb_count", 8'(stb_seen), 8'd1);

    check("capq_drained", 8'(capq.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
